// File: rtl/attn_coef_loader.sv
// Multi-head attention coefficient loader: streams NUM_HEADS*A_DEPTH words from the
// coefficient BRAM into a flat register bank, with configurable read latency, reload and abort.
module attn_coef_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned A_DEPTH    = 16,
  parameter int unsigned NUM_HEADS  = 2,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned A_ADDR_W   = (NUM_HEADS * A_DEPTH > 1) ?
                                      $clog2(NUM_HEADS * A_DEPTH) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start_i,
  input  logic                                   clear_i,
  output logic                                   busy_o,
  output logic                                   a_rdy_o,
  input  logic [DATA_WIDTH-1:0]                  a_bram_dout,
  output logic                                   a_bram_enb,
  output logic [A_ADDR_W-1:0]                    a_bram_addrb,
  output logic [NUM_HEADS*A_DEPTH*DATA_WIDTH-1:0] a_flat_o
);

  localparam int unsigned TOTAL = NUM_HEADS * A_DEPTH;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] TotalCnt = CNT_W'(TOTAL);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      cap_cnt_q, cap_cnt_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic [A_ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0] word_q [TOTAL];
  logic                  cap_en;
  logic                  load_go;

  // Clear discards whatever is still in flight, including a capture due this cycle.
  assign cap_en  = vld_q[RD_LAT-1] && !clear_i;
  assign load_go = !clear_i && start_i && (state_q == StIdle || state_q == StDone);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: if (start_i) state_d = StIssue;
        StIssue:        if (issue_cnt_q == LastIdx) state_d = StDrain;
        // Enter DONE on the final capture so ready rises the cycle the last word lands.
        StDrain:        if (cap_en && cap_cnt_q == LastIdx) state_d = StDone;
        default:        state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    a_bram_enb   = (state_q == StIssue);
    busy_o       = (state_q == StIssue) || (state_q == StDrain);
    a_rdy_o      = (state_q == StDone);
    a_bram_addrb = a_bram_enb ? A_ADDR_W'(issue_cnt_q) : addr_q;
  end

  // Counters, valid pipe and held address
  always_comb begin
    issue_cnt_d = issue_cnt_q;
    cap_cnt_d   = cap_cnt_q;
    addr_d      = addr_q;
    vld_d[0]    = a_bram_enb;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
    if (clear_i) begin
      vld_d       = '0;
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
    end else if (load_go) begin
      issue_cnt_d = '0;
      cap_cnt_d   = '0;
    end else begin
      if (a_bram_enb) begin
        addr_d = a_bram_addrb;
        if (issue_cnt_q != TotalCnt) issue_cnt_d = issue_cnt_q + CNT_W'(1);
      end
      if (cap_en && cap_cnt_q != TotalCnt) cap_cnt_d = cap_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      cap_cnt_q   <= '0;
      vld_q       <= '0;
      addr_q      <= '0;
    end else begin
      issue_cnt_q <= issue_cnt_d;
      cap_cnt_q   <= cap_cnt_d;
      vld_q       <= vld_d;
      addr_q      <= addr_d;
    end
  end

  // Coefficient bank; words not yet rewritten keep their previous contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TOTAL; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TOTAL; i++) begin
        if (cap_en && cap_cnt_q == CNT_W'(i)) word_q[i] <= a_bram_dout;
      end
    end
  end

  for (genvar n = 0; n < TOTAL; n++) begin : g_flat
    assign a_flat_o[n*DATA_WIDTH +: DATA_WIDTH] = word_q[n];
  end

endmodule

// File: tb/tb_attn_coef_loader.sv
// Directed bench for attn_coef_loader: two instances (read latency 1 and 3), TOTAL=8,
// each fed by a small behavioural BRAM with matching latency.
module tb_attn_coef_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Latency-1 instance
  logic        start1, clear1, busy1, rdy1, enb1;
  logic [2:0]  addr1;
  logic [7:0]  dout1;
  logic [63:0] flat1;
  logic [7:0]  mem1 [8];

  // Latency-3 instance
  logic        start3, clear3, busy3, rdy3, enb3;
  logic [2:0]  addr3;
  logic [7:0]  dout3;
  logic [63:0] flat3;
  logic [7:0]  mem3 [8];
  logic [7:0]  d3 [3];

  attn_coef_loader #(
    .DATA_WIDTH(8), .A_DEPTH(4), .NUM_HEADS(2), .RD_LAT(1)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start1),
    .clear_i     (clear1),
    .busy_o      (busy1),
    .a_rdy_o     (rdy1),
    .a_bram_dout (dout1),
    .a_bram_enb  (enb1),
    .a_bram_addrb(addr1),
    .a_flat_o    (flat1)
  );

  attn_coef_loader #(
    .DATA_WIDTH(8), .A_DEPTH(4), .NUM_HEADS(2), .RD_LAT(3)
  ) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start3),
    .clear_i     (clear3),
    .busy_o      (busy3),
    .a_rdy_o     (rdy3),
    .a_bram_dout (dout3),
    .a_bram_enb  (enb3),
    .a_bram_addrb(addr3),
    .a_flat_o    (flat3)
  );

  always @(posedge clk) begin
    if (enb1) dout1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (enb3) d3[0] <= mem3[addr3];
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign dout3 = d3[2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse1();
    start1 = 1'b1;
    step();
    start1 = 1'b0;
  endtask

  task automatic check_words1(input string tag, input logic [7:0] base);
    for (int n = 0; n < 8; n++) begin
      check_eq(tag, 64'(flat1[n*8 +: 8]), 64'(base + 8'(n)));
    end
  endtask

  int cnt;

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; clear1 = 1'b0;
    start3 = 1'b0; clear3 = 1'b0;
    for (int n = 0; n < 8; n++) begin
      mem1[n] = 8'(n + 1);
      mem3[n] = 8'(n + 1);
    end
    step();
    step();
    check_eq("rst_flat", flat1, 64'h0);
    check_eq("rst_rdy", 64'(rdy1), 64'h0);
    check_eq("rst_busy", 64'(busy1), 64'h0);
    check_eq("rst_enb", 64'(enb1), 64'h0);
    check_eq("rst_addr", 64'(addr1), 64'h0);
    rst_n = 1'b1;
    step();

    // 1) basic load, latency 1
    pulse1();
    for (int c = 1; c <= 11; c++) begin
      check_eq("t1_enb", 64'(enb1), 64'(c <= 8));
      if (c <= 8) check_eq("t1_addr", 64'(addr1), 64'(c - 1));
      check_eq("t1_rdy", 64'(rdy1), 64'(c >= 10));
      check_eq("t1_busy", 64'(busy1), 64'(c <= 9));
      step();
    end
    check_words1("t1_word", 8'h01);

    // 2) latency 3
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      check_eq("t2_enb", 64'(enb3), 64'(c <= 8));
      check_eq("t2_rdy", 64'(rdy3), 64'(c >= 12));
      if (c == 4) check_eq("t2_nocap", 64'(flat3[7:0]), 64'h0);
      if (c == 5) check_eq("t2_cap0", 64'(flat3[7:0]), 64'h1);
      step();
    end
    for (int n = 0; n < 8; n++) begin
      check_eq("t2_word", 64'(flat3[n*8 +: 8]), 64'(n + 1));
    end

    // 3) reload from DONE
    for (int n = 0; n < 8; n++) mem1[n] = 8'hA0 + 8'(n);
    pulse1();
    for (int c = 1; c <= 10; c++) begin
      check_eq("t3_rdy", 64'(rdy1), 64'(c >= 10));
      check_eq("t3_busy", 64'(busy1), 64'(c <= 9));
      step();
    end
    check_words1("t3_word", 8'hA0);

    // 4) start held high for 20 cycles from IDLE
    clear1 = 1'b1;
    step();
    clear1 = 1'b0;
    check_eq("t4_clr_busy", 64'(busy1), 64'h0);
    check_eq("t4_clr_rdy", 64'(rdy1), 64'h0);
    start1 = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (enb1) cnt++;
      if (c == 10) check_eq("t4_rdy10", 64'(rdy1), 64'h1);
      if (c == 11) check_eq("t4_rdy11", 64'(rdy1), 64'h0);
      if (c == 20) begin
        check_eq("t4_rdy20", 64'(rdy1), 64'h1);
        start1 = 1'b0;
      end
    end
    check_eq("t4_issues", 64'(cnt), 64'd16);
    check_eq("t4_rdy_end", 64'(rdy1), 64'h1);

    // 5) clear at cycle 4 of a load
    for (int n = 0; n < 8; n++) mem1[n] = 8'(n + 1);
    pulse1();
    step();
    step();
    step();
    clear1 = 1'b1;
    step();
    clear1 = 1'b0;
    check_eq("t5_busy", 64'(busy1), 64'h0);
    check_eq("t5_enb", 64'(enb1), 64'h0);
    check_eq("t5_word3_kept", 64'(flat1[31:24]), 64'hA3);
    for (int c = 0; c < 3; c++) begin
      check_eq("t5_rdy", 64'(rdy1), 64'h0);
      step();
    end
    start1 = 1'b1;
    clear1 = 1'b1;
    step();
    start1 = 1'b0;
    clear1 = 1'b0;
    check_eq("t5_both_busy", 64'(busy1), 64'h0);
    pulse1();
    for (int c = 1; c <= 10; c++) begin
      check_eq("t5_rdy_reload", 64'(rdy1), 64'(c >= 10));
      step();
    end
    check_words1("t5_word", 8'h01);

    // 6) async reset during DRAIN
    pulse1();
    for (int c = 1; c < 9; c++) step();
    check_eq("t6_drain_busy", 64'(busy1), 64'h1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_flat", flat1, 64'h0);
    check_eq("t6_rdy", 64'(rdy1), 64'h0);
    check_eq("t6_busy", 64'(busy1), 64'h0);
    check_eq("t6_enb", 64'(enb1), 64'h0);
    check_eq("t6_addr", 64'(addr1), 64'h0);
    #2;
    rst_n = 1'b1;
    step();
    check_eq("t6_post_flat", flat1, 64'h0);
    step();
    check_eq("t6_post_flat2", flat1, 64'h0);
    check_eq("t6_post_busy", 64'(busy1), 64'h0);
    pulse1();
    for (int c = 1; c <= 10; c++) begin
      check_eq("t6_rdy", 64'(rdy1), 64'(c >= 10));
      step();
    end
    check_words1("t6_word", 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
